// File: rtl/mem_access.sv
// Memory-stage access controller: issues one dcache request per memory instruction,
// stalls upstream until dhit, tracks the LL/SC link and latches halt.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_in,
    input  logic              memREN_in,
    input  logic              memWEN_in,
    input  logic              ll_in,
    input  logic              sc_in,
    input  logic              halt_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [ADDR_W-1:0] store_in,
    input  logic              advance_in,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemload,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [ADDR_W-1:0] dmemstore,
    output logic [ADDR_W-1:0] dmemload_out,
    output logic              mem_stall,
    output logic              memwb_enable,
    output logic              halt_out
);
    // Word-granular address comparisons ignore the byte offset.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_reg;
    logic              link_valid_reg;
    logic [ADDR_W-1:0] link_addr_reg;
    logic [ADDR_W-1:0] data_q_reg;

    logic op;
    logic link_match;
    logic snoop_hit_now;
    logic sc_fail;
    logic access;
    logic complete;
    logic ll_snoop_same;

    assign op            = valid_in & (memREN_in | memWEN_in);
    assign link_match    = link_valid_reg &
                           ((link_addr_reg & WORD_MASK) == (addr_in & WORD_MASK));
    assign snoop_hit_now = ccinv &
                           ((ccsnoopaddr & WORD_MASK) == (link_addr_reg & WORD_MASK));
    assign sc_fail       = op & sc_in & (~link_match | snoop_hit_now);
    assign access        = (state_reg == IDLE) & op & ~sc_fail;
    assign complete      = access & dhit;
    assign ll_snoop_same = ccinv &
                           ((ccsnoopaddr & WORD_MASK) == (addr_in & WORD_MASK));

    // Requests follow EX/MEM directly so the cache sees them in the issue cycle;
    // everything is forced quiet while reset is applied.
    always_comb begin
        dmemREN      = 1'b0;
        dmemWEN      = 1'b0;
        dmemaddr     = '0;
        dmemstore    = '0;
        dmemload_out = '0;
        mem_stall    = 1'b0;
        if (!RST) begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        dmemREN      = memREN_in;
                        dmemWEN      = memWEN_in;
                        dmemaddr     = addr_in;
                        dmemstore    = store_in;
                        mem_stall    = ~dhit;
                        dmemload_out = sc_in ? {{(ADDR_W-1){1'b0}}, dhit} : dmemload;
                    end else if (!sc_fail) begin
                        dmemload_out = dmemload;
                    end
                end
                HELD: begin
                    dmemload_out = data_q_reg;
                end
                HALTED: begin
                    mem_stall    = 1'b1;
                    dmemload_out = data_q_reg;
                end
                default: begin
                    dmemload_out = '0;
                end
            endcase
        end
    end

    assign memwb_enable = ~mem_stall;
    assign halt_out     = (state_reg == HALTED) & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            link_valid_reg <= 1'b0;
            link_addr_reg  <= '0;
            data_q_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_in & halt_in) begin
                        state_reg <= HALTED;
                    end else if (complete) begin
                        data_q_reg <= sc_in ? {{(ADDR_W-1){1'b0}}, 1'b1} : dmemload;
                        if (!advance_in) state_reg <= HELD;
                    end else if (sc_fail) begin
                        data_q_reg <= '0;
                        if (!advance_in) state_reg <= HELD;
                    end
                end
                HELD: begin
                    if (advance_in) state_reg <= IDLE;
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // A new LL link survives a concurrent snoop unless the snoop hits the new word.
            if (complete & memREN_in & ll_in) begin
                link_addr_reg  <= addr_in;
                link_valid_reg <= ~ll_snoop_same;
            end else if (snoop_hit_now | (complete & memWEN_in & (sc_in | link_match))) begin
                link_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_access;
    logic        clk;
    logic        rst;
    logic        valid_in, memREN_in, memWEN_in, ll_in, sc_in, halt_in;
    logic [31:0] addr_in, store_in;
    logic        advance_in, dhit;
    logic [31:0] dmemload;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload_out;
    logic        mem_stall, memwb_enable, halt_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: outstanding result held, halted, link register, held result.
    bit          m_hold, m_halted, m_lv;
    logic [31:0] m_la, m_dq;

    // Expected outputs for the current cycle.
    bit          e_ren, e_wen, e_stall, chk_out, chk_req;
    logic [31:0] e_addr, e_store, e_out;

    mem_access #(.ADDR_W(32)) dut (
        .CLK(clk), .RST(rst),
        .valid_in(valid_in), .memREN_in(memREN_in), .memWEN_in(memWEN_in),
        .ll_in(ll_in), .sc_in(sc_in), .halt_in(halt_in),
        .addr_in(addr_in), .store_in(store_in), .advance_in(advance_in),
        .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload_out(dmemload_out), .mem_stall(mem_stall),
        .memwb_enable(memwb_enable), .halt_out(halt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    function automatic bit sc_allowed();
        if (!sc_in) return 1'b1;
        return m_lv && same_word(m_la, addr_in) && !(ccinv && same_word(ccsnoopaddr, m_la));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_outputs();
        bit is_mem;
        e_ren = 0; e_wen = 0; e_stall = 0; chk_out = 0; chk_req = 0;
        e_addr = '0; e_store = '0; e_out = '0;
        is_mem = valid_in && (memREN_in || memWEN_in);
        if (m_halted) begin
            e_stall = 1;
        end else if (m_hold) begin
            e_out = m_dq; chk_out = 1;
        end else if (is_mem) begin
            if (sc_allowed()) begin
                e_ren = memREN_in; e_wen = memWEN_in;
                e_addr = addr_in; e_store = store_in;
                chk_req = 1; e_stall = !dhit;
                if (dhit) begin
                    chk_out = 1;
                    e_out = sc_in ? 32'd1 : dmemload;
                end
            end else begin
                e_out = '0; chk_out = 1;
            end
        end
    endtask

    task automatic model_update();
        bit          is_mem, ok, lv_n;
        logic [31:0] la_n;
        if (rst) begin
            m_hold = 0; m_halted = 0; m_lv = 0; m_la = '0; m_dq = '0;
            return;
        end
        is_mem = valid_in && (memREN_in || memWEN_in);
        ok     = sc_allowed();
        lv_n   = m_lv;
        la_n   = m_la;
        if (ccinv && same_word(ccsnoopaddr, m_la)) lv_n = 0;
        if (m_halted) begin
            m_halted = 1;
        end else if (m_hold) begin
            if (advance_in) m_hold = 0;
        end else if (valid_in && halt_in) begin
            m_halted = 1;
        end else if (is_mem && ok && dhit) begin
            m_dq   = sc_in ? 32'd1 : dmemload;
            m_hold = !advance_in;
            if (memREN_in && ll_in) begin
                la_n = addr_in;
                lv_n = !(ccinv && same_word(ccsnoopaddr, addr_in));
            end else if (memWEN_in && (sc_in || same_word(addr_in, m_la))) begin
                lv_n = 0;
            end
        end else if (is_mem && !ok) begin
            m_dq   = '0;
            m_hold = !advance_in;
        end
        m_lv = lv_n;
        m_la = la_n;
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) begin
            model_outputs();
            check("dmemREN", {31'b0, dmemREN}, {31'b0, e_ren});
            check("dmemWEN", {31'b0, dmemWEN}, {31'b0, e_wen});
            check("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
            check("memwb_enable", {31'b0, memwb_enable}, {31'b0, !e_stall});
            check("halt_out", {31'b0, halt_out}, {31'b0, m_halted});
            if (chk_req) begin
                check("dmemaddr", dmemaddr, e_addr);
                check("dmemstore", dmemstore, e_store);
            end
            if (chk_out) check("dmemload_out", dmemload_out, e_out);
            $display("cyc %0d v=%0b r=%0b w=%0b ll=%0b sc=%0b a=%h hit=%0b ren=%0b wen=%0b stall=%0b out=%h halt=%0b",
                     cyc, valid_in, memREN_in, memWEN_in, ll_in, sc_in, addr_in, dhit,
                     dmemREN, dmemWEN, mem_stall, dmemload_out, halt_out);
        end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic set_op(input bit v, input bit r, input bit w, input bit ll, input bit sc,
                          input bit h, input logic [31:0] a, input logic [31:0] d);
        valid_in = v; memREN_in = r; memWEN_in = w; ll_in = ll; sc_in = sc; halt_in = h;
        addr_in = a; store_in = d;
    endtask

    task automatic set_idle();
        set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        dhit = 0; ccinv = 0; advance_in = 1;
    endtask

    // One LL that completes immediately and advances.
    task automatic do_ll(input logic [31:0] a);
        set_op(1, 1, 0, 1, 0, 0, a, 32'h0);
        dhit = 1; advance_in = 1; dmemload = 32'h1234_5678;
        step();
    endtask

    task automatic do_sc(input logic [31:0] a, input logic [31:0] d, input bit snoop,
                         input logic [31:0] sa);
        set_op(1, 0, 1, 0, 1, 0, a, d);
        dhit = 1; advance_in = 1; ccinv = snoop; ccsnoopaddr = sa;
        step();
        ccinv = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0104;
            2:       return 32'h0000_0200;
            3:       return 32'h0000_0202;
            default: return 32'h0000_0300;
        endcase
    endfunction

    initial begin
        bit new_instr;
        int kind;
        set_idle();
        dmemload = '0; ccsnoopaddr = '0;
        m_hold = 0; m_halted = 0; m_lv = 0; m_la = '0; m_dq = '0;
        rst = 1;
        step(); step();
        rst = 0;
        step();

        // LW with dhit in the third cycle, advancing on completion.
        set_op(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        dmemload = 32'hDEAD_BEEF; dhit = 0; advance_in = 0;
        step(); step();
        dhit = 1; advance_in = 1;
        step();
        set_idle(); step();

        // Same LW but held three cycles while the cache data changes.
        set_op(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        dmemload = 32'hDEAD_BEEF; dhit = 0; advance_in = 0;
        step(); step();
        dhit = 1;
        step();
        dhit = 0; dmemload = 32'h0;
        step(); step(); step();
        advance_in = 1;
        step();
        set_idle(); step();

        // LL then SC succeeds, second SC fails.
        do_ll(32'h200);
        do_sc(32'h200, 32'd5, 0, 32'h0);
        do_sc(32'h200, 32'd5, 0, 32'h0);
        set_idle(); step();

        // Snoop of a neighbouring word leaves the link intact.
        do_ll(32'h200);
        set_idle(); ccinv = 1; ccsnoopaddr = 32'h204; step();
        do_sc(32'h200, 32'd6, 0, 32'h0);

        // Snoop of the linked word, before and during the SC.
        do_ll(32'h200);
        set_idle(); ccinv = 1; ccsnoopaddr = 32'h200; step();
        do_sc(32'h200, 32'd7, 0, 32'h0);
        do_ll(32'h200);
        do_sc(32'h200, 32'd8, 1, 32'h200);
        set_idle(); step();

        // Halt: sticky, stalls, ignores memory ops until reset.
        set_op(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 1) set_op(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
            else            set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
            dhit = (i % 2 == 0);
            step();
        end
        set_idle();
        rst = 1; step();
        rst = 0; step();

        // Reset during an outstanding LW abandons it and clears the link.
        do_ll(32'h100);
        set_op(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        dhit = 0; advance_in = 0;
        step();
        rst = 1; step();
        rst = 0; set_idle(); step();
        do_sc(32'h100, 32'd9, 0, 32'h0);
        set_idle(); step();

        // Random traffic; the instruction stays put until the pipeline advances.
        new_instr = 1;
        for (int n = 0; n < 400; n++) begin
            if (new_instr) begin
                kind = $urandom_range(0, 6);
                case (kind)
                    0: set_op(1, 0, 0, 0, 0, 0, pick_addr(), $urandom);
                    1: set_op(1, 1, 0, 0, 0, 0, pick_addr(), $urandom);
                    2: set_op(1, 1, 0, 1, 0, 0, pick_addr(), $urandom);
                    3: set_op(1, 0, 1, 0, 0, 0, pick_addr(), $urandom);
                    4, 5: set_op(1, 0, 1, 0, 1, 0, pick_addr(), $urandom);
                    default: set_op(0, 0, 0, 0, 0, 0, pick_addr(), $urandom);
                endcase
            end
            dhit        = ($urandom_range(0, 2) == 0);
            dmemload    = $urandom;
            ccinv       = ($urandom_range(0, 4) == 0);
            ccsnoopaddr = pick_addr();
            model_outputs();
            advance_in  = e_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            step();
            new_instr = advance_in;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
